// File: rtl/keypad_scan_if.sv
// Key-code handshake between keypad_scan (master) and the command decoder (slave).
interface keypad_scan_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] cmd;
  logic              valid;
  logic              ack;
  logic              overflow;

  modport master (output cmd, output valid, output overflow, input ack);
  modport slave  (input cmd, input valid, input overflow, output ack);
endinterface

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: row strobing, per-frame debounce with ghost rejection, key-code FIFO.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CODE_W       = 4,
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE     = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] V,
  input  logic [COLS-1:0] H,
  keypad_scan_if.master   kbd
);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int MATCH_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 2 || DEBOUNCE < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || (1 << CODE_W) < ROWS * COLS ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan: illegal parameter combination");
  end

  // A frame's verdict: exactly one contact gives a key, anything else is NONE.
  typedef struct packed {
    logic              key;
    logic [CODE_W-1:0] code;
  } cand_t;

  logic               active_q, active_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0]  acc_code_q, acc_code_d;
  cand_t              prev_q, prev_d, stable_q, stable_d, cand;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [CODE_W-1:0]  mem_q [FIFO_DEPTH];

  logic               sample, frame_end, stable_change, new_press, push_req;
  logic               empty, full, pop, do_push, drop;
  logic [1:0]         tot_cnt;
  logic [CODE_W-1:0]  tot_code;

  // Scan timing: the first edge after reset only arms the scanner, so row 0 gets a full dwell.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    active_d  = 1'b1;
    row_d     = row_q;
    dwell_d   = dwell_q;
    sample    = active_q && (dwell_q == DWELL_W'(SCAN_DIV - 1));
    frame_end = sample && (row_q == ROW_W'(ROWS - 1));
    if (active_q) begin
      if (sample) begin
        dwell_d = '0;
        row_d   = frame_end ? '0 : row_q + ROW_W'(1);
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  assign V = active_q ? (ROWS'(1) << row_q) : '0;

  // Contact count saturates at 2: only "none", "one" and "several" matter.
  always_comb begin
    tot_cnt  = acc_cnt_q;
    tot_code = acc_code_q;
    if (sample) begin
      for (int c = 0; c < COLS; c++) begin
        if (H[c]) begin
          tot_code = CODE_W'(int'(row_q) * COLS + c);
          if (tot_cnt != 2'd2) tot_cnt = tot_cnt + 2'd1;
        end
      end
    end
    acc_cnt_d  = frame_end ? '0 : tot_cnt;
    acc_code_d = frame_end ? '0 : tot_code;
    cand.key   = (tot_cnt == 2'd1);
    cand.code  = cand.key ? tot_code : '0;
  end

  always_comb begin
    prev_d        = prev_q;
    match_d       = match_q;
    stable_d      = stable_q;
    stable_change = 1'b0;
    if (frame_end) begin
      prev_d = cand;
      if (cand == prev_q) begin
        if (match_q != MATCH_W'(DEBOUNCE)) match_d = match_q + MATCH_W'(1);
      end else begin
        match_d = MATCH_W'(1);
      end
      if (match_d == MATCH_W'(DEBOUNCE) && cand != stable_q) begin
        stable_d      = cand;
        stable_change = 1'b1;
      end
    end
  end

  assign new_press = stable_change && cand.key;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_run_q, rep_run_d;
  logic             rep_push;

  // Frames are counted only while the same key stays stable; any stable change restarts.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_run_d = rep_run_q;
    rep_push  = 1'b0;
    if (frame_end) begin
      if (stable_change || !stable_q.key) begin
        rep_cnt_d = '0;
        rep_run_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
        if (rep_cnt_d == (rep_run_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
          rep_push  = 1'b1;
          rep_cnt_d = '0;
          rep_run_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_run_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_run_q <= rep_run_d;
    end
  end

  assign push_req = new_press || rep_push;
`else
  assign push_req = new_press;
`endif

  // A pop in the same cycle frees the slot a push into a full queue needs.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = kbd.ack && !empty;
    do_push  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
    ovf_d    = drop ? 1'b1 : (pop ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) in sequential blocks so every flop sees pre-edge values.
    if (!rst_n) begin
      active_q   <= 1'b0;
      row_q      <= '0;
      dwell_q    <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      match_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      match_q    <= match_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= stable_d.code;
  end

  assign kbd.cmd      = empty ? '0 : mem_q[rd_ptr_q];
  assign kbd.valid    = !empty;
  assign kbd.overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives H from V, a monitor pops and checks codes.
`timescale 1ns/1ps
module tb_keypad_scan;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int FRAME = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_EXTRA = 3;
`else
  localparam int HOLD_EXTRA = 12;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ROWS-1:0] V;
  logic [COLS-1:0] H;
  logic [15:0]     keys = '0;

  int          tests = 0;
  int          fails = 0;
  bit          ack_en = 1'b0;
  logic [3:0]  exp_q[$];

  keypad_scan_if #(.CODE_W(4)) kbd ();

  keypad_scan #(
    .ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE(3),
    .FIFO_DEPTH(4), .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .V     (V),
    .H     (H),
    .kbd   (kbd)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed switch connects the strobed row to its column.
  always_comb begin
    H = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (V[r] && keys[r * COLS + c]) H[c] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] key_bit(input int idx);
    logic [15:0] k;
    k = '0;
    k[idx] = 1'b1;
    return k;
  endfunction

  // Monitor: whenever enabled and a code is presented, compare with the scoreboard and pop it.
  initial begin
    kbd.ack = 1'b0;
    forever begin
      @(negedge clk);
      kbd.ack = 1'b0;
      if (rst_n && ack_en && kbd.valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: cmd=%0d presented, no code expected", kbd.cmd);
        end else begin
          check("cmd", {28'd0, kbd.cmd}, {28'd0, exp_q.pop_front()});
        end
        kbd.ack = 1'b1;
      end
    end
  end

  // Returns on the negedge of the first cycle of a frame (row 0, dwell 0).
  task automatic sync_frame();
    int n = 0;
    while (V !== 4'b1000 && n < 64) begin @(negedge clk); n++; end
    while (V !== 4'b0001 && n < 64) begin @(negedge clk); n++; end
    check("sync_frame", n < 64, 1);
  endtask

  task automatic wait_frames(input int f);
    repeat (f * FRAME) @(negedge clk);
  endtask

  // Called at frame start right after the key is applied; counts cycles to valid.
  task automatic expect_event(input string name, input logic [3:0] code, input int lat);
    int n = 0;
    exp_q.push_back(code);
    do begin @(negedge clk); n++; end while (kbd.valid !== 1'b1 && n < 300);
    check({name, "_latency"}, n, lat);
  endtask

  task automatic set_ack_en(input bit en);
    @(posedge clk);
    ack_en = en;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and row strobe sequence
    repeat (3) @(negedge clk);
    check("rst_v", {28'd0, V}, 0);
    check("rst_cmd", {28'd0, kbd.cmd}, 0);
    check("rst_valid", kbd.valid, 0);
    check("rst_overflow", kbd.overflow, 0);
    rst_n = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      logic [3:0] exp_v;
      @(negedge clk);
      exp_v = 4'(1 << ((i / 4) % 4));
      check("v_seq", {28'd0, V}, {28'd0, exp_v});
    end

    // Single held key, row 2 col 1 -> code 9
    set_ack_en(1'b1);
    sync_frame();
    keys = key_bit(9);
    expect_event("press9", 4'd9, 3 * FRAME);
    @(negedge clk);
    check("valid_after_ack", kbd.valid, 0);
    repeat (HOLD_EXTRA * FRAME) @(negedge clk);
    keys = '0;
    wait_frames(4);
    check("held_no_repeat", exp_q.size(), 0);

    // Bouncing contact row 0 col 3 for six frames, then held -> one event, code 3
    sync_frame();
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? key_bit(3) : 16'd0;
      wait_frames(1);
    end
    keys = key_bit(3);
    expect_event("bounce3", 4'd3, 3 * FRAME);
    keys = '0;
    wait_frames(4);
    check("bounce_single", exp_q.size(), 0);

    // Two keys at once are rejected; releasing one leaves code 7
    sync_frame();
    keys = key_bit(0) | key_bit(7);
    wait_frames(5);
    keys = key_bit(7);
    expect_event("ghost7", 4'd7, 3 * FRAME);
    keys = '0;
    wait_frames(4);
    check("ghost_drained", exp_q.size(), 0);

    // Five presses into a four-deep queue with no consumer
    set_ack_en(1'b0);
    sync_frame();
    for (int k = 1; k <= 5; k++) begin
      keys = key_bit(k);
      wait_frames(4);
      keys = '0;
      wait_frames(4);
      if (k <= 4) exp_q.push_back(4'(k));
    end
    check("ovf_set", kbd.overflow, 1);
    check("ovf_valid", kbd.valid, 1);
    check("ovf_head", {28'd0, kbd.cmd}, 1);
    set_ack_en(1'b1);
    repeat (2) @(negedge clk);
    check("ovf_clear", kbd.overflow, 0);
    repeat (8) @(negedge clk);
    check("drain_valid", kbd.valid, 0);
    check("drain_queue", exp_q.size(), 0);

    // Reset mid-frame discards queued code 6
    set_ack_en(1'b0);
    sync_frame();
    keys = key_bit(6);
    wait_frames(4);
    check("pre_rst_valid", kbd.valid, 1);
    check("pre_rst_cmd", {28'd0, kbd.cmd}, 6);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    keys = '0;
    @(negedge clk);
    check("mid_rst_valid", kbd.valid, 0);
    check("mid_rst_v", {28'd0, V}, 0);
    rst_n = 1'b1;
    set_ack_en(1'b1);
    wait_frames(6);
    check("post_rst_valid", kbd.valid, 0);

`ifdef KEYPAD_REPEAT_EN
    // Held code 5 for 20 frames: debounce push, +8 frames, then every 2 frames until release settles
    sync_frame();
    keys = key_bit(5);
    repeat (7) exp_q.push_back(4'd5);
    wait_frames(20);
    keys = '0;
    wait_frames(6);
    check("repeat_count", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
